// File: rtl/type_decoder_if.sv
// Decode-stage opcode classifier bus: opcode qualifier in, one-hot class flags out.
interface type_decoder_if;
    logic       in_valid;
    logic [6:0] opcode;
    logic       out_valid;
    logic       r_type;
    logic       i_type;
    logic       load;
    logic       store;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic       illegal;

    modport master (
        output in_valid, opcode,
        input  out_valid, r_type, i_type, load, store, branch,
               jal, jalr, lui, auipc, illegal
    );

    modport slave (
        input  in_valid, opcode,
        output out_valid, r_type, i_type, load, store, branch,
               jal, jalr, lui, auipc, illegal
    );
endinterface

// File: rtl/type_decoder.sv
// RV32I major-opcode classifier: one registered one-hot class flag per live
// instruction, or illegal when the opcode is outside the supported set.
module type_decoder (
    input  logic          clk,
    input  logic          rst_n,
    type_decoder_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int CLS_R      = 0;
    localparam int CLS_I      = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;
    localparam int NUM_CLS    = 9;

    logic [NUM_CLS-1:0] match;
    logic [NUM_CLS-1:0] class_d;
    logic               illegal_d;

    logic [NUM_CLS-1:0] class_q;
    logic               illegal_q;
    logic               valid_q;

    // Exact 7-bit compare; FENCE and SYSTEM deliberately fall through to illegal.
    always_comb begin
        match = '0;
        case (bus.opcode)
            OPC_OP:     match[CLS_R]      = 1'b1;
            OPC_OP_IMM: match[CLS_I]      = 1'b1;
            OPC_LOAD:   match[CLS_LOAD]   = 1'b1;
            OPC_STORE:  match[CLS_STORE]  = 1'b1;
            OPC_BRANCH: match[CLS_BRANCH] = 1'b1;
            OPC_JAL:    match[CLS_JAL]    = 1'b1;
            OPC_JALR:   match[CLS_JALR]   = 1'b1;
            OPC_LUI:    match[CLS_LUI]    = 1'b1;
            OPC_AUIPC:  match[CLS_AUIPC]  = 1'b1;
            default:    match = '0;
        endcase
    end

    always_comb begin
        class_d   = '0;
        illegal_d = 1'b0;
        if (bus.in_valid) begin
            class_d   = match;
            illegal_d = ~(|match);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            class_q   <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            class_q   <= class_d;
            illegal_q <= illegal_d;
            valid_q   <= bus.in_valid;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.r_type    = class_q[CLS_R];
    assign bus.i_type    = class_q[CLS_I];
    assign bus.load      = class_q[CLS_LOAD];
    assign bus.store     = class_q[CLS_STORE];
    assign bus.branch    = class_q[CLS_BRANCH];
    assign bus.jal       = class_q[CLS_JAL];
    assign bus.jalr      = class_q[CLS_JALR];
    assign bus.lui       = class_q[CLS_LUI];
    assign bus.auipc     = class_q[CLS_AUIPC];
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_type_decoder.sv
// Directed bench for type_decoder; observed word is
// {out_valid, r_type, i_type, load, store, branch, jal, jalr, lui, auipc, illegal}.
module tb_type_decoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    type_decoder_if bus ();

    type_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] E_IDLE    = 11'b00000000000;
    localparam logic [10:0] E_R       = 11'b11000000000;
    localparam logic [10:0] E_I       = 11'b10100000000;
    localparam logic [10:0] E_LOAD    = 11'b10010000000;
    localparam logic [10:0] E_STORE   = 11'b10001000000;
    localparam logic [10:0] E_BRANCH  = 11'b10000100000;
    localparam logic [10:0] E_JAL     = 11'b10000010000;
    localparam logic [10:0] E_JALR    = 11'b10000001000;
    localparam logic [10:0] E_LUI     = 11'b10000000100;
    localparam logic [10:0] E_AUIPC   = 11'b10000000010;
    localparam logic [10:0] E_ILLEGAL = 11'b10000000001;

    localparam logic [6:0] SWEEP_OPS [9] = '{
        7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
        7'b0010111, 7'b1101111, 7'b1100111, 7'b0110111
    };
    localparam logic [10:0] SWEEP_EXP [9] = '{
        E_R, E_I, E_LOAD, E_STORE, E_BRANCH, E_AUIPC, E_JAL, E_JALR, E_LUI
    };
    localparam logic [6:0] BAD_OPS [6] = '{
        7'b1111111, 7'b0001111, 7'b1110011, 7'b0000000, 7'b0110010, 7'b1010011
    };

    function automatic logic [10:0] observed();
        return {bus.out_valid, bus.r_type, bus.i_type, bus.load, bus.store,
                bus.branch, bus.jal, bus.jalr, bus.lui, bus.auipc, bus.illegal};
    endfunction

    // Apply inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [6:0] op);
        rst_n        = r;
        bus.in_valid = v;
        bus.opcode   = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 7'b0110011);
            checks++;
            if (observed() !== E_IDLE) begin
                errors++;
                $display("FAIL reset edge %0d: got %b expected %b", k, observed(), E_IDLE);
            end
        end
    endtask

    task automatic test_class_sweep();
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1, SWEEP_OPS[k]);
            checks++;
            if (observed() !== SWEEP_EXP[k]) begin
                errors++;
                $display("FAIL sweep opcode %b: got %b expected %b",
                         SWEEP_OPS[k], observed(), SWEEP_EXP[k]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, BAD_OPS[k]);
            checks++;
            if (observed() !== E_ILLEGAL) begin
                errors++;
                $display("FAIL illegal opcode %b: got %b expected %b",
                         BAD_OPS[k], observed(), E_ILLEGAL);
            end
        end
    endtask

    task automatic test_invalid();
        step(1'b1, 1'b0, 7'b0110011);
        checks++;
        if (observed() !== E_IDLE) begin
            errors++;
            $display("FAIL invalid op: got %b expected %b", observed(), E_IDLE);
        end
        step(1'b1, 1'b0, 7'b1111111);
        checks++;
        if (observed() !== E_IDLE) begin
            errors++;
            $display("FAIL invalid bad-op: got %b expected %b", observed(), E_IDLE);
        end
        step(1'b1, 1'b1, 7'b0010011);
        checks++;
        if (observed() !== E_I) begin
            errors++;
            $display("FAIL valid after idle: got %b expected %b", observed(), E_I);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 7'b1101111);
        checks++;
        if (observed() !== E_JAL) begin
            errors++;
            $display("FAIL b2b jal: got %b expected %b", observed(), E_JAL);
        end
        step(1'b1, 1'b1, 7'b1100111);
        checks++;
        if (observed() !== E_JALR) begin
            errors++;
            $display("FAIL b2b jalr: got %b expected %b", observed(), E_JALR);
        end
        checks++;
        if ((bus.jal & bus.jalr) !== 1'b0) begin
            errors++;
            $display("FAIL b2b exclusive: jal=%b jalr=%b expected not both 1", bus.jal, bus.jalr);
        end
        step(1'b1, 1'b1, 7'b1101111);
        checks++;
        if (observed() !== E_JAL) begin
            errors++;
            $display("FAIL b2b jal again: got %b expected %b", observed(), E_JAL);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 7'b0110111);
        checks++;
        if (observed() !== E_LUI) begin
            errors++;
            $display("FAIL mid lui before reset: got %b expected %b", observed(), E_LUI);
        end
        step(1'b0, 1'b1, 7'b0110111);
        checks++;
        if (observed() !== E_IDLE) begin
            errors++;
            $display("FAIL mid reset edge: got %b expected %b", observed(), E_IDLE);
        end
        step(1'b1, 1'b1, 7'b0110111);
        checks++;
        if (observed() !== E_LUI) begin
            errors++;
            $display("FAIL mid resume lui: got %b expected %b", observed(), E_LUI);
        end
        step(1'b1, 1'b1, 7'b0100011);
        checks++;
        if (observed() !== E_STORE) begin
            errors++;
            $display("FAIL mid resume store: got %b expected %b", observed(), E_STORE);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        test_reset();
        test_class_sweep();
        test_illegal();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
